// File: rtl/buffer_read_serializer_pkg.sv
// buf_rd_pkg: shared FSM encoding, index sizing and word extraction for the
// buffer read serializer. Rev 1.0
`default_nettype none

package buf_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  // Upper bounds that make word_slice usable for any legal WIDTH/J pairing.
  localparam int unsigned MAX_WORD_W = 64;
  localparam int unsigned MAX_GRP_W  = 1024;

  function automatic int unsigned idx_width(input int unsigned j);
    return (j <= 2) ? 1 : $clog2(j);
  endfunction

  function automatic logic [MAX_WORD_W-1:0] word_slice(
    input logic [MAX_GRP_W-1:0] grp,
    input int unsigned          idx,
    input int unsigned          width
  );
    logic [MAX_GRP_W-1:0]  shifted;
    logic [MAX_WORD_W-1:0] mask;
    shifted = grp >> (idx * width);
    mask    = (width >= MAX_WORD_W) ? '1
            : ((MAX_WORD_W'(1) << width) - MAX_WORD_W'(1));
    return MAX_WORD_W'(shifted) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_read_serializer.sv
// buffer_read_serializer: pulls one J-word group from the width-converting
// buffer and streams it out LSB word first on a valid/ready port. Rev 1.0
`default_nettype none

module buffer_read_serializer
  import buf_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int J     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buf_empty,
  input  logic                 buf_valid,
  input  logic [WIDTH*J-1:0]   buf_par_out,
  output logic                 buf_r_en,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int IDX_W = idx_width(J);
  localparam int GRP_W = WIDTH * J;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(J - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [GRP_W-1:0]   group_q, group_d;
  logic [MAX_GRP_W-1:0] grp_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      group_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      group_q <= group_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    group_d = group_q;
    case (state_q)
      ST_IDLE: begin
        if (!buf_empty) state_d = ST_REQ;
      end
      // buf_valid during the request cycle cannot belong to this read.
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (buf_valid) begin
          group_d = buf_par_out;
          index_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_ready) begin
          if (index_q == LAST_IDX) begin
            index_d = '0;
            state_d = ST_IDLE;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grp_ext            = '0;
    grp_ext[GRP_W-1:0] = group_q;
  end

  // Outputs depend only on registered state, never on the inputs.
  always_comb begin
    buf_r_en  = (state_q == ST_REQ);
    out_valid = (state_q == ST_SHIFT);
    out_last  = (state_q == ST_SHIFT) && (index_q == LAST_IDX);
    busy      = (state_q != ST_IDLE);
    out_data  = '0;
    if (state_q == ST_SHIFT)
      out_data = WIDTH'(word_slice(grp_ext, 32'(index_q), WIDTH));
  end

endmodule

`default_nettype wire

// File: tb/tb_buffer_read_serializer.sv
// tb_buffer_read_serializer: table-driven cycle vectors plus directed
// sequences for empty buffer, asynchronous reset and back-to-back groups.
`default_nettype none

module tb_buffer_read_serializer;

  logic        clk;
  logic        rst;
  logic        buf_empty;
  logic        buf_valid;
  logic [31:0] buf_par_out;
  logic        buf_r_en;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  buffer_read_serializer #(.WIDTH(8), .J(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .buf_empty   (buf_empty),
    .buf_valid   (buf_valid),
    .buf_par_out (buf_par_out),
    .buf_r_en    (buf_r_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        empty;
    logic        valid;
    logic [31:0] par;
    logic        ready;
    logic        x_ren;
    logic        x_vld;
    logic [7:0]  x_data;
    logic        x_last;
    logic        x_busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] G1 = {8'd10, 8'd15, 8'd25, 8'd12};
  localparam logic [31:0] G2 = 32'h44332211;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  function automatic void add(input logic e, input logic v, input logic [31:0] p,
                              input logic r, input logic xr, input logic xv,
                              input logic [7:0] xd, input logic xl, input logic xb);
    vec_t t;
    t.empty = e; t.valid = v; t.par = p; t.ready = r;
    t.x_ren = xr; t.x_vld = xv; t.x_data = xd; t.x_last = xl; t.x_busy = xb;
    vecs.push_back(t);
  endfunction

  function automatic logic [31:0] obs();
    return {20'd0, buf_r_en, out_valid, out_last, busy, out_data};
  endfunction

  function automatic logic [31:0] pack_exp(input logic xr, input logic xv, input logic xl,
                                           input logic xb, input logic [7:0] xd);
    return {20'd0, xr, xv, xl, xb, xd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        ren_prev, ren_cur;
    int          reads, delivered, cyc;
    int          ren_cyc[$];
    logic [7:0]  words[$];
    logic [31:0] grps[2];
    logic [7:0]  exp_words[8];

    rst = 1'b1; buf_empty = 1'b1; buf_valid = 1'b0; buf_par_out = '0; out_ready = 1'b1;
    #2 rst = 1'b0;
    tick(); tick();
    check("reset_state", obs(), pack_exp(0, 0, 0, 0, 8'h00));
    #3 rst = 1'b1;
    tick();
    check("idle_after_reset", obs(), pack_exp(0, 0, 0, 0, 8'h00));

    // basic read
    add(1,0,0,1,   0,0,8'h00,0,0);
    add(0,0,0,1,   1,0,8'h00,0,1);
    add(1,0,0,1,   0,0,8'h00,0,1);
    add(1,1,G1,1,  0,1,8'h0C,0,1);
    add(1,0,0,1,   0,1,8'h19,0,1);
    add(1,0,0,1,   0,1,8'h0F,0,1);
    add(1,0,0,1,   0,1,8'h0A,1,1);
    add(1,0,0,1,   0,0,8'h00,0,0);
    // backpressure on beat 1, buf_empty low meanwhile
    add(0,0,0,1,   1,0,8'h00,0,1);
    add(1,0,0,1,   0,0,8'h00,0,1);
    add(1,1,G1,1,  0,1,8'h0C,0,1);
    add(1,0,0,1,   0,1,8'h19,0,1);
    for (int k = 0; k < 5; k++) add(0,0,0,0, 0,1,8'h19,0,1);
    add(1,0,0,1,   0,1,8'h0F,0,1);
    add(1,0,0,1,   0,1,8'h0A,1,1);
    add(1,0,0,1,   0,0,8'h00,0,0);
    // delayed valid: spurious valid in REQ, real one 4 cycles after r_en
    add(0,0,0,0,     1,0,8'h00,0,1);
    add(0,1,JUNK,0,  0,0,8'h00,0,1);
    add(0,0,JUNK,0,  0,0,8'h00,0,1);
    add(1,0,JUNK,0,  0,0,8'h00,0,1);
    add(0,0,JUNK,0,  0,0,8'h00,0,1);
    add(1,1,G2,0,    0,1,8'h11,0,1);
    add(1,0,0,0,     0,1,8'h11,0,1);
    add(1,0,0,1,     0,1,8'h22,0,1);
    add(1,0,0,1,     0,1,8'h33,0,1);
    add(1,0,0,1,     0,1,8'h44,1,1);
    add(1,0,0,1,     0,0,8'h00,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      buf_empty = vecs[i].empty; buf_valid = vecs[i].valid;
      buf_par_out = vecs[i].par; out_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d", i), obs(),
            pack_exp(vecs[i].x_ren, vecs[i].x_vld, vecs[i].x_last,
                     vecs[i].x_busy, vecs[i].x_data));
    end

    // empty buffer for 50 cycles
    buf_empty = 1'b1; buf_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check($sformatf("empty_c%0d", i), obs(), pack_exp(0, 0, 0, 0, 8'h00));
    end

    // asynchronous reset after beat 2 of 4
    buf_empty = 1'b0; tick();
    buf_empty = 1'b1; tick();
    buf_valid = 1'b1; buf_par_out = G1; tick();
    buf_valid = 1'b0; tick(); tick();
    check("pre_reset_beat2", obs(), pack_exp(0, 1, 0, 1, 8'h0F));
    #2 rst = 1'b0;
    #1 check("async_reset_now", obs(), pack_exp(0, 0, 0, 0, 8'h00));
    tick(); tick();
    #3 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("post_reset_c%0d", i), obs(), pack_exp(0, 0, 0, 0, 8'h00));
    end

    // back-to-back groups against a 1-cycle-latency buffer model
    grps[0] = {8'd1, 8'd2, 8'd3, 8'd4};
    grps[1] = {8'd5, 8'd6, 8'd7, 8'd8};
    exp_words = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5};
    reads = 0; delivered = 0; ren_prev = 1'b0; ren_cur = buf_r_en; out_ready = 1'b1;
    for (cyc = 0; cyc < 30; cyc++) begin
      buf_empty = (reads >= 2);
      buf_valid = ren_prev;
      if (ren_prev && delivered < 2) begin
        buf_par_out = grps[delivered];
        delivered++;
      end else begin
        buf_par_out = JUNK;
      end
      ren_prev = ren_cur;
      tick();
      ren_cur = buf_r_en;
      if (buf_r_en) begin
        reads++;
        ren_cyc.push_back(cyc);
      end
      if (out_valid) words.push_back(out_data);
    end
    check("b2b_ren_count", 32'(ren_cyc.size()), 32'd2);
    if (ren_cyc.size() == 2)
      check("b2b_ren_spacing", 32'(ren_cyc[1] - ren_cyc[0]), 32'd7);
    check("b2b_word_count", 32'(words.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < words.size())
        check($sformatf("b2b_word%0d", i), {24'd0, words[i]}, {24'd0, exp_words[i]});
      else
        check($sformatf("b2b_word%0d", i), 32'hFFFF_FFFF, {24'd0, exp_words[i]});
    end
    check("b2b_final_idle", obs(), pack_exp(0, 0, 0, 0, 8'h00));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
